// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port (WE3/A3/WD3/SFlag).
// Port 0 is the vector ALU and port 1 is the memory load unit. The block uses a
// round-robin grant and a one-entry registered output stage. It filters illegal
// addresses and exports a pending-write scoreboard for hazard detection.
module regfile_wb_arbiter #(
    parameter int LANES     = 6,
    parameter int LANE_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int VEC_BASE  = 5,
    parameter int VEC_DEPTH = 10,
    parameter int ERRCNT_W  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [1:0][ADDR_W-1:0]              req_addr,
    input  logic [1:0][LANES*LANE_W-1:0]        req_data,
    input  logic [1:0]                          req_sflag,
    input  logic                                stall,
    output logic                                WE3,
    output logic [ADDR_W-1:0]                   A3,
    output logic [LANES*LANE_W-1:0]             WD3,
    output logic                                SFlag,
    output logic [2**ADDR_W-1:0]                pending,
    output logic                                err,
    output logic [ERRCNT_W-1:0]                 err_cnt
);

    localparam int DATA_W = LANES * LANE_W;

    // Legal address bounds, pre-sized to the index width so compares stay exact.
    localparam logic [ADDR_W-1:0] VEC_LO = ADDR_W'(VEC_BASE);
    localparam logic [ADDR_W-1:0] VEC_HI = ADDR_W'(VEC_BASE + VEC_DEPTH - 1);
    localparam logic [ADDR_W-1:0] SCL_HI = ADDR_W'(LANES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   a3_q;
    logic [DATA_W-1:0]   wd3_q;
    logic                sflag_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic [ERRCNT_W-1:0] err_cnt_d;
    logic                rr_ptr_q;
    logic                rr_ptr_d;

    logic                can_accept;
    logic                accept;
    logic                grant_idx;
    logic                legal;
    logic                load;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_sflag;

    // Grant selection, legality check and accept strobe for the current cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        grant_idx = 1'b0;
        req_ready = 2'b00;
        rr_ptr_d  = rr_ptr_q;
        err_cnt_d = err_cnt_q;

        // A cycle in reset accepts nothing. Otherwise a requester would see ready
        // for a request that the reset then discards.
        can_accept = ~rst & ~stall;

        if (req_valid == 2'b11) begin
            grant_idx = rr_ptr_q;
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end

        accept    = can_accept & (|req_valid);
        sel_addr  = req_addr[grant_idx];
        sel_sflag = req_sflag[grant_idx];

        if (sel_sflag) begin
            legal = (sel_addr <= SCL_HI);
        end else begin
            legal = (sel_addr >= VEC_LO) && (sel_addr <= VEC_HI);
        end

        load = accept & legal;

        if (accept) begin
            req_ready[grant_idx] = 1'b1;
            rr_ptr_d             = ~grant_idx;
            if (!legal && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // Output-stage FSM plus held entry, round-robin pointer and error tracking.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q   <= EMPTY;
            a3_q      <= '0;
            wd3_q     <= '0;
            sflag_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            rr_ptr_q  <= 1'b0;
        end else begin
            err_q     <= accept & ~legal;
            err_cnt_q <= err_cnt_d;
            rr_ptr_q  <= rr_ptr_d;

            if (!stall) begin
                unique case (state_q)
                    EMPTY:   state_q <= load ? FULL : EMPTY;
                    FULL:    state_q <= load ? FULL : EMPTY;
                    default: state_q <= EMPTY;
                endcase
            end

            // A3/WD3/SFlag keep their last value unless a legal entry is loaded.
            if (load) begin
                a3_q    <= sel_addr;
                wd3_q   <= req_data[grant_idx];
                sflag_q <= sel_sflag;
            end
        end
    end

    // Pending-write scoreboard: one-hot of the held index while an entry is held.
    always_comb begin
        pending = '0;
        if (state_q == FULL) begin
            pending[a3_q] = 1'b1;
        end
    end

    // The held entry writes in every cycle that is not stalled. During reset the
    // entry is discarded instead of written.
    assign WE3     = (state_q == FULL) & ~stall & ~rst;
    assign A3      = a3_q;
    assign WD3     = wd3_q;
    assign SFlag   = sflag_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with hand-computed expected values.
module tb_regfile_wb_arbiter;

    localparam int LANES  = 6;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 4;
    localparam int DATA_W = LANES * LANE_W;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0][ADDR_W-1:0]      req_addr;
    logic [1:0][DATA_W-1:0]      req_data;
    logic [1:0]                  req_sflag;
    logic                        stall;
    logic                        WE3;
    logic [ADDR_W-1:0]           A3;
    logic [DATA_W-1:0]           WD3;
    logic                        SFlag;
    logic [2**ADDR_W-1:0]        pending;
    logic                        err;
    logic [7:0]                  err_cnt;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sflag (req_sflag),
        .stall     (stall),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .SFlag     (SFlag),
        .pending   (pending),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        req_sflag = 2'b00;
        stall     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic drive(input int p, input logic [3:0] addr, input logic sf, input logic [47:0] d);
        req_valid[p] = 1'b1;
        req_addr[p]  = addr;
        req_sflag[p] = sf;
        req_data[p]  = d;
    endtask

    // Boundary table: {sflag, addr, legal}
    logic [5:0] bnd [7] = '{
        {1'b0, 4'd4,  1'b0},
        {1'b0, 4'd5,  1'b1},
        {1'b0, 4'd14, 1'b1},
        {1'b0, 4'd15, 1'b0},
        {1'b1, 4'd5,  1'b1},
        {1'b1, 4'd6,  1'b0},
        {1'b1, 4'd0,  1'b1}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [3:0] exp_a3  [4] = '{4'd5, 4'd14, 4'd5, 4'd14};
        logic [5:0] row;

        // Reset state
        do_reset();
        check("rst_we3", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_sflag", SFlag, 0);
        check("rst_pending", pending, 0);
        check("rst_err", err, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_ready", req_ready, 0);

        // 1: single vector write from port 0
        drive(0, 4'd6, 1'b0, 48'h06_05_04_03_02_01);
        #1;
        check("t1_ready", req_ready, 2'b01);
        step();
        idle();
        #1;
        check("t1_we3", WE3, 1);
        check("t1_a3", A3, 6);
        check("t1_sflag", SFlag, 0);
        check("t1_wd3", WD3, 48'h06_05_04_03_02_01);
        check("t1_pending", pending, 16'h0040);
        step();
        check("t1_we3_off", WE3, 0);
        check("t1_pending_off", pending, 0);

        // 2: both valid, round robin 0,1,0,1 with back-to-back writes
        do_reset();
        drive(0, 4'd5, 1'b0, 48'hAAAA_AAAA_AAAA);
        drive(1, 4'd14, 1'b0, 48'hBBBB_BBBB_BBBB);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_ready%0d", k), req_ready, exp_rdy[k]);
            step();
            check($sformatf("t2_we3_%0d", k), WE3, 1);
            check($sformatf("t2_a3_%0d", k), A3, exp_a3[k]);
        end
        idle();
        step();
        check("t2_we3_done", WE3, 0);

        // 3: stall holds the entry
        do_reset();
        drive(0, 4'd9, 1'b0, 48'h1234_5678_9ABC);
        #1;
        check("t3_ready", req_ready, 2'b01);
        step();
        idle();
        stall = 1'b1;
        drive(1, 4'd10, 1'b0, 48'h0);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_we3_stall%0d", k), WE3, 0);
            check($sformatf("t3_a3_stall%0d", k), A3, 9);
            check($sformatf("t3_pend_stall%0d", k), pending, 16'h0200);
            check($sformatf("t3_ready_stall%0d", k), req_ready, 0);
            step();
        end
        idle();
        #1;
        check("t3_we3_release", WE3, 1);
        check("t3_a3_release", A3, 9);
        check("t3_wd3_release", WD3, 48'h1234_5678_9ABC);
        step();
        check("t3_we3_empty", WE3, 0);
        check("t3_pend_empty", pending, 0);

        // 4: illegal requests and counter saturation
        do_reset();
        drive(1, 4'd3, 1'b0, 48'h0);
        #1;
        check("t4_ready_a", req_ready, 2'b10);
        step();
        check("t4_err_a", err, 1);
        check("t4_cnt_a", err_cnt, 1);
        check("t4_we3_a", WE3, 0);
        drive(1, 4'd7, 1'b1, 48'h0);
        #1;
        check("t4_ready_b", req_ready, 2'b10);
        step();
        check("t4_err_b", err, 1);
        check("t4_cnt_b", err_cnt, 2);
        check("t4_we3_b", WE3, 0);
        idle();
        step();
        check("t4_err_clr", err, 0);
        check("t4_cnt_hold", err_cnt, 2);
        drive(1, 4'd15, 1'b0, 48'h0);
        for (int k = 0; k < 300; k++) begin
            step();
        end
        check("t4_cnt_sat", err_cnt, 255);
        check("t4_err_sat", err, 1);
        idle();
        step();
        check("t4_cnt_sat_hold", err_cnt, 255);
        check("t4_err_sat_clr", err, 0);

        // 5: scalar write, then reset while an entry is held
        do_reset();
        drive(0, 4'd2, 1'b1, 48'h0000_0000_00AB);
        #1;
        step();
        idle();
        #1;
        check("t5_we3", WE3, 1);
        check("t5_sflag", SFlag, 1);
        check("t5_a3", A3, 2);
        check("t5_wd3", WD3, 48'h0000_0000_00AB);
        stall = 1'b1;
        rst   = 1'b1;
        #1;
        check("t5_we3_in_rst", WE3, 0);
        step();
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        check("t5_we3_after_rst", WE3, 0);
        check("t5_pend_after_rst", pending, 0);
        check("t5_a3_after_rst", A3, 0);
        check("t5_sflag_after_rst", SFlag, 0);

        // 6: only port 1 valid with rr_ptr=0, then rr_ptr back at 0
        do_reset();
        drive(1, 4'd7, 1'b0, 48'h7777_7777_7777);
        #1;
        check("t6_ready_p1", req_ready, 2'b10);
        step();
        idle();
        drive(0, 4'd8, 1'b0, 48'h8888_8888_8888);
        drive(1, 4'd11, 1'b0, 48'hBBBB_0000_BBBB);
        #1;
        check("t6_we3", WE3, 1);
        check("t6_a3", A3, 7);
        check("t6_ready_both", req_ready, 2'b01);
        step();
        idle();
        #1;
        check("t6_a3_next", A3, 8);

        // 7: legality boundaries
        do_reset();
        for (int k = 0; k < 7; k++) begin
            row = bnd[k];
            drive(0, row[4:1], row[5], 48'hC0DE_0000_0000 | 48'(k));
            #1;
            check($sformatf("t7_ready%0d", k), req_ready, 2'b01);
            step();
            idle();
            #1;
            check($sformatf("t7_we3_%0d", k), WE3, row[0]);
            check($sformatf("t7_err_%0d", k), err, !row[0]);
            step();
        end
        check("t7_cnt", err_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
